// File: rtl/t30_mem_node.sv
// t30_mem_node: memory node for the node array, built from one storage array.
// Neighbours on the left/right/up/down ports push values into the node and pop them back out.
// MODE 0 gives stack (LIFO) order and MODE 1 gives queue (FIFO) order.
//
// Ports:
//   i_clk, i_reset                       clock and synchronous active-high reset
//   i_<dir>_in_data/_in_valid            write offer from a neighbour
//   o_<dir>_in_ready                     write accepted this cycle
//   o_<dir>_out_data/_out_valid          head value offered to a neighbour
//   i_<dir>_out_ready                    neighbour takes the offered value
//   o_count                              number of stored entries
module t30_mem_node #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 15,
    parameter int unsigned MODE  = 0
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [WIDTH-1:0]           i_left_in_data,
    input  logic                       i_left_in_valid,
    output logic                       o_left_in_ready,
    output logic [WIDTH-1:0]           o_left_out_data,
    output logic                       o_left_out_valid,
    input  logic                       i_left_out_ready,
    input  logic [WIDTH-1:0]           i_right_in_data,
    input  logic                       i_right_in_valid,
    output logic                       o_right_in_ready,
    output logic [WIDTH-1:0]           o_right_out_data,
    output logic                       o_right_out_valid,
    input  logic                       i_right_out_ready,
    input  logic [WIDTH-1:0]           i_up_in_data,
    input  logic                       i_up_in_valid,
    output logic                       o_up_in_ready,
    output logic [WIDTH-1:0]           o_up_out_data,
    output logic                       o_up_out_valid,
    input  logic                       i_up_out_ready,
    input  logic [WIDTH-1:0]           i_down_in_data,
    input  logic                       i_down_in_valid,
    output logic                       o_down_in_ready,
    output logic [WIDTH-1:0]           o_down_out_data,
    output logic                       o_down_out_valid,
    input  logic                       i_down_out_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Port index order doubles as write priority and offer rotation order.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [1:0]       r_offer;
    logic             r_blank;

    logic [WIDTH-1:0] w_in_data [4];
    logic [3:0]       w_in_valid;
    logic [3:0]       w_in_ready;
    logic [3:0]       w_out_ready;
    logic [3:0]       w_out_valid;
    logic [WIDTH-1:0] w_push_data;
    logic [WIDTH-1:0] w_head;
    logic [WIDTH-1:0] w_out_data;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_wr_idx;
    logic [CW-1:0]    w_count_d;
    logic [AW-1:0]    w_rd_ptr_d;
    logic [AW-1:0]    w_wr_ptr_d;
    logic [1:0]       w_offer_d;
    logic             w_blank;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_in_data[0] = i_left_in_data;
    assign w_in_data[1] = i_right_in_data;
    assign w_in_data[2] = i_up_in_data;
    assign w_in_data[3] = i_down_in_data;
    assign w_in_valid   = {i_down_in_valid, i_up_in_valid, i_right_in_valid, i_left_in_valid};
    assign w_out_ready  = {i_down_out_ready, i_up_out_ready, i_right_out_ready, i_left_out_ready};

    // Handshakes stay quiet while reset is held and for the cycle after it.
    assign w_blank = r_blank | i_reset;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // Fixed-priority write arbitration; no bypass when full.
    always_comb begin
        w_in_ready  = '0;
        w_push_data = '0;
        if (!w_blank && !w_full) begin
            if (w_in_valid[0]) begin
                w_in_ready[0] = 1'b1;
                w_push_data   = w_in_data[0];
            end else if (w_in_valid[1]) begin
                w_in_ready[1] = 1'b1;
                w_push_data   = w_in_data[1];
            end else if (w_in_valid[2]) begin
                w_in_ready[2] = 1'b1;
                w_push_data   = w_in_data[2];
            end else if (w_in_valid[3]) begin
                w_in_ready[3] = 1'b1;
                w_push_data   = w_in_data[3];
            end
        end
    end

    assign w_push      = |w_in_ready;
    assign w_out_valid = (!w_blank && !w_empty) ? (4'b0001 << r_offer) : 4'b0000;
    assign w_pop       = w_out_valid[r_offer] & w_out_ready[r_offer];

    // Head selection and write slot.
    always_comb begin
        w_top_idx = AW'(r_count - CW'(1));
        w_head    = '0;
        if (!w_empty) begin
            w_head = (MODE == 0) ? r_mem[w_top_idx] : r_mem[r_rd_ptr];
        end
        w_out_data = w_blank ? '0 : w_head;
        if (MODE == 0) begin
            // On push+pop the old top leaves and the new value takes its slot.
            w_wr_idx = w_pop ? w_top_idx : AW'(r_count);
        end else begin
            w_wr_idx = r_wr_ptr;
        end
    end

    // Next-state for count, queue pointers and offer pointer.
    always_comb begin
        w_count_d  = r_count;
        w_rd_ptr_d = r_rd_ptr;
        w_wr_ptr_d = r_wr_ptr;
        if (w_push && !w_pop) begin
            w_count_d = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_d = r_count - CW'(1);
        end
        if (MODE != 0) begin
            if (w_push) begin
                w_wr_ptr_d = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                w_rd_ptr_d = (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
            end
        end
        // Hold the offer while the selected neighbour is taking data, rotate otherwise.
        w_offer_d = (!w_empty && w_out_ready[r_offer]) ? r_offer : r_offer + 2'd1;
    end

    always_ff @(posedge i_clk) begin
        r_blank <= i_reset;
        if (i_reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_offer  <= 2'd0;
        end else begin
            r_count  <= w_count_d;
            r_rd_ptr <= w_rd_ptr_d;
            r_wr_ptr <= w_wr_ptr_d;
            r_offer  <= w_offer_d;
        end
    end

    // Storage is not cleared by reset; w_push is already low while reset is high.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[w_wr_idx] <= w_push_data;
        end
    end

    assign o_left_in_ready   = w_in_ready[0];
    assign o_right_in_ready  = w_in_ready[1];
    assign o_up_in_ready     = w_in_ready[2];
    assign o_down_in_ready   = w_in_ready[3];
    assign o_left_out_valid  = w_out_valid[0];
    assign o_right_out_valid = w_out_valid[1];
    assign o_up_out_valid    = w_out_valid[2];
    assign o_down_out_valid  = w_out_valid[3];
    assign o_left_out_data   = w_out_data;
    assign o_right_out_data  = w_out_data;
    assign o_up_out_data     = w_out_data;
    assign o_down_out_data   = w_out_data;
    assign o_count           = r_count;

endmodule

// File: tb/tb_t30_mem_node.sv
// tb_t30_mem_node: scoreboard bench for t30_mem_node.
// u_stk is a default stack node (MODE 0, DEPTH 15) and u_que is a queue node (MODE 1, DEPTH 4).
// Stimulus pushes the expected {port, data} of every pop into a queue.
// A monitor process compares each observed pop against the head of that queue.
module tb_t30_mem_node;

    localparam int W = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [W-1:0] s_in_data [4];
    logic [W-1:0] s_out_data [4];
    logic [3:0]   s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [3:0]   s_count;

    logic [W-1:0] q_in_data [4];
    logic [W-1:0] q_out_data [4];
    logic [3:0]   q_in_valid, q_in_ready, q_out_valid, q_out_ready;
    logic [2:0]   q_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [12:0] exp_s[$];
    logic [12:0] exp_q[$];

    always #5 clk = ~clk;

    t30_mem_node u_stk (
        .i_clk(clk), .i_reset(rst),
        .i_left_in_data(s_in_data[0]), .i_left_in_valid(s_in_valid[0]),
        .o_left_in_ready(s_in_ready[0]), .o_left_out_data(s_out_data[0]),
        .o_left_out_valid(s_out_valid[0]), .i_left_out_ready(s_out_ready[0]),
        .i_right_in_data(s_in_data[1]), .i_right_in_valid(s_in_valid[1]),
        .o_right_in_ready(s_in_ready[1]), .o_right_out_data(s_out_data[1]),
        .o_right_out_valid(s_out_valid[1]), .i_right_out_ready(s_out_ready[1]),
        .i_up_in_data(s_in_data[2]), .i_up_in_valid(s_in_valid[2]),
        .o_up_in_ready(s_in_ready[2]), .o_up_out_data(s_out_data[2]),
        .o_up_out_valid(s_out_valid[2]), .i_up_out_ready(s_out_ready[2]),
        .i_down_in_data(s_in_data[3]), .i_down_in_valid(s_in_valid[3]),
        .o_down_in_ready(s_in_ready[3]), .o_down_out_data(s_out_data[3]),
        .o_down_out_valid(s_out_valid[3]), .i_down_out_ready(s_out_ready[3]),
        .o_count(s_count)
    );

    t30_mem_node #(.WIDTH(W), .DEPTH(4), .MODE(1)) u_que (
        .i_clk(clk), .i_reset(rst),
        .i_left_in_data(q_in_data[0]), .i_left_in_valid(q_in_valid[0]),
        .o_left_in_ready(q_in_ready[0]), .o_left_out_data(q_out_data[0]),
        .o_left_out_valid(q_out_valid[0]), .i_left_out_ready(q_out_ready[0]),
        .i_right_in_data(q_in_data[1]), .i_right_in_valid(q_in_valid[1]),
        .o_right_in_ready(q_in_ready[1]), .o_right_out_data(q_out_data[1]),
        .o_right_out_valid(q_out_valid[1]), .i_right_out_ready(q_out_ready[1]),
        .i_up_in_data(q_in_data[2]), .i_up_in_valid(q_in_valid[2]),
        .o_up_in_ready(q_in_ready[2]), .o_up_out_data(q_out_data[2]),
        .o_up_out_valid(q_out_valid[2]), .i_up_out_ready(q_out_ready[2]),
        .i_down_in_data(q_in_data[3]), .i_down_in_valid(q_in_valid[3]),
        .o_down_in_ready(q_in_ready[3]), .o_down_out_data(q_out_data[3]),
        .o_down_out_valid(q_out_valid[3]), .i_down_out_ready(q_out_ready[3]),
        .o_count(q_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [12:0] ent(input int p, input logic [W-1:0] d);
        return {2'(p), d};
    endfunction

    // Monitor: samples 2 time units before each rising edge, after all stimulus has settled.
    always @(negedge clk) begin
        #3;
        if (!rst) begin
            check("stk_one_offer", 32'($countones(s_out_valid) <= 1), 32'd1);
            check("que_one_offer", 32'($countones(q_out_valid) <= 1), 32'd1);
            for (int p = 0; p < 4; p++) begin
                if (s_out_valid[p] && s_out_ready[p]) begin
                    if (exp_s.size() == 0) check("stk_unexpected_pop", 32'(ent(p, s_out_data[p])), 32'hFFFF_FFFF);
                    else check("stk_pop", 32'(ent(p, s_out_data[p])), 32'(exp_s.pop_front()));
                end
                if (q_out_valid[p] && q_out_ready[p]) begin
                    if (exp_q.size() == 0) check("que_unexpected_pop", 32'(ent(p, q_out_data[p])), 32'hFFFF_FFFF);
                    else check("que_pop", 32'(ent(p, q_out_data[p])), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Offers one value on port p and holds it until accepted (bounded).
    task automatic push(input bit q, input int p, input logic [W-1:0] d, input string name);
        bit ok = 1'b0;
        @(posedge clk); #1;
        if (q) begin q_in_data[p] = d; q_in_valid[p] = 1'b1; end
        else begin s_in_data[p] = d; s_in_valid[p] = 1'b1; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (q ? q_in_ready[p] : s_in_ready[p]) begin ok = 1'b1; break; end
        end
        check(name, 32'(ok), 32'd1);
        @(posedge clk); #1;
        if (q) q_in_valid[p] = 1'b0;
        else s_in_valid[p] = 1'b0;
    endtask

    task automatic wait_count(input bit q, input int target, input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int'(q ? 4'(q_count) : s_count) == target) begin ok = 1'b1; break; end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_offer(input bit q, input int p, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (q ? q_out_valid[p] : s_out_valid[p]) begin ok = 1'b1; break; end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int p = 0; p < 4; p++) begin
            s_in_data[p] = '0;
            q_in_data[p] = '0;
        end
        s_in_valid = '0; s_out_ready = '0;
        q_in_valid = '0; q_out_ready = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_stk_count", 32'(s_count), 32'd0);
        check("reset_que_count", 32'(q_count), 32'd0);
        check("reset_stk_valid", 32'(s_out_valid), 32'd0);

        // Stack order
        push(0, 2, 11'd5, "t1_push5");
        push(0, 2, 11'd10, "t1_push10");
        push(0, 2, 11'h7FD, "t1_push_m3");
        @(negedge clk);
        check("t1_count3", 32'(s_count), 32'd3);
        #1;
        exp_s.push_back(ent(3, 11'h7FD));
        exp_s.push_back(ent(3, 11'd10));
        exp_s.push_back(ent(3, 11'd5));
        s_out_ready[3] = 1'b1;
        wait_count(0, 0, 30, "t1_drain");
        #1 s_out_ready[3] = 1'b0;
        check("t1_down_valid_low", 32'(s_out_valid[3]), 32'd0);
        check("t1_empty_data", 32'(s_out_data[3]), 32'd0);

        // Queue order with pointer wrap
        for (int v = 1; v <= 6; v++) exp_q.push_back(ent(1, 11'(v)));
        for (int v = 1; v <= 4; v++) push(1, 0, 11'(v), "t2_push");
        @(negedge clk);
        check("t2_count4", 32'(q_count), 32'd4);
        #1 q_out_ready[1] = 1'b1;
        wait_count(1, 2, 20, "t2_pop2");
        #1 q_out_ready[1] = 1'b0;
        push(1, 0, 11'd5, "t2_push5");
        push(1, 0, 11'd6, "t2_push6");
        q_out_ready[1] = 1'b1;
        wait_count(1, 0, 30, "t2_drain");
        #1 q_out_ready[1] = 1'b0;

        // Full node refuses writes until a pop
        for (int v = 11; v <= 14; v++) push(1, 0, 11'(v), "t3_fill");
        @(negedge clk);
        #1 q_in_data[0] = 11'd99; q_in_valid[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t3_full_ready_low", 32'(q_in_ready[0]), 32'd0);
            check("t3_full_count", 32'(q_count), 32'd4);
        end
        exp_q.push_back(ent(2, 11'd11));
        wait_offer(1, 2, "t3_up_offer");
        #1 q_out_ready[2] = 1'b1;
        @(posedge clk); #1 q_out_ready[2] = 1'b0;
        @(negedge clk);
        check("t3_ready_after_pop", 32'(q_in_ready[0]), 32'd1);
        @(posedge clk); #1 q_in_valid[0] = 1'b0;
        @(negedge clk);
        check("t3_refilled", 32'(q_count), 32'd4);
        #1;
        exp_q.push_back(ent(3, 11'd12));
        exp_q.push_back(ent(3, 11'd13));
        exp_q.push_back(ent(3, 11'd14));
        exp_q.push_back(ent(3, 11'd99));
        q_out_ready[3] = 1'b1;
        wait_count(1, 0, 30, "t3_drain");
        #1 q_out_ready[3] = 1'b0;

        // Write arbitration
        @(posedge clk); #1;
        s_in_data[0] = 11'd7; s_in_data[2] = 11'd8; s_in_data[3] = 11'd9;
        s_in_valid[0] = 1'b1; s_in_valid[2] = 1'b1; s_in_valid[3] = 1'b1;
        @(negedge clk);
        check("t4_ready_left", 32'(s_in_ready), 32'b0001);
        @(posedge clk); #1 s_in_valid[0] = 1'b0;
        @(negedge clk);
        check("t4_ready_up", 32'(s_in_ready), 32'b0100);
        @(posedge clk); #1 s_in_valid[2] = 1'b0;
        @(negedge clk);
        check("t4_ready_down", 32'(s_in_ready), 32'b1000);
        @(posedge clk); #1 s_in_valid[3] = 1'b0;
        @(negedge clk);
        check("t4_count3", 32'(s_count), 32'd3);
        #1;
        exp_s.push_back(ent(0, 11'd9));
        exp_s.push_back(ent(0, 11'd8));
        exp_s.push_back(ent(0, 11'd7));
        s_out_ready[0] = 1'b1;
        wait_count(0, 0, 30, "t4_drain");
        #1 s_out_ready[0] = 1'b0;

        // Offer rotation reaches RIGHT within 4 edges
        push(0, 0, 11'd42, "t5_push42");
        exp_s.push_back(ent(1, 11'd42));
        s_out_ready[1] = 1'b1;
        wait_count(0, 0, 5, "t5_right_within_4");
        #1 s_out_ready[1] = 1'b0;

        // Simultaneous push/pop on the stack, then reset mid-offer
        push(0, 0, 11'd1, "t6_push1");
        push(0, 0, 11'd2, "t6_push2");
        wait_offer(0, 3, "t6_down_offer");
        #1;
        exp_s.push_back(ent(3, 11'd2));
        s_out_ready[3] = 1'b1;
        s_in_data[2] = 11'd50; s_in_valid[2] = 1'b1;
        #1 check("t6_push_ready", 32'(s_in_ready[2]), 32'd1);
        @(posedge clk); #1 s_out_ready[3] = 1'b0; s_in_valid[2] = 1'b0;
        @(negedge clk);
        check("t6_count2", 32'(s_count), 32'd2);
        check("t6_new_top", 32'(s_out_data[0]), 32'd50);
        #1 s_in_data[0] = 11'd77; s_in_valid[0] = 1'b1; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("t6_rst_valid", 32'(s_out_valid), 32'd0);
        check("t6_rst_ready", 32'(s_in_ready), 32'd0);
        check("t6_rst_count", 32'(s_count), 32'd0);
        check("t6_rst_data", 32'(s_out_data[2]), 32'd0);
        @(posedge clk); #1 s_in_valid[0] = 1'b0;
        @(negedge clk);
        check("t6_rst_no_push", 32'(s_count), 32'd0);

        repeat (2) @(posedge clk);
        check("stk_all_popped", 32'(exp_s.size()), 32'd0);
        check("que_all_popped", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
